// File: rtl/brick_pkg.sv
// Shared types and constants for the breakout brick field.
// State encoding, colour palette and a geometry helper.
package brick_pkg;

    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DRAW_ALL,
        CHECK,
        ERASE
    } state_t;

    // One past the far edge of the last brick along an axis.
    function automatic int field_extent(
        input int origin,
        input int pitch,
        input int count,
        input int size
    );
        return origin + (count - 1) * pitch + size;
    endfunction

endpackage

// File: rtl/brick_field_rect_raster.sv
// Streams the pixels of one W x H rectangle, x fastest.
// Coordinates hold while the sink stalls; start restarts at pixel 0.
module rect_raster #(
    parameter int COORD_W = 8,
    parameter int W       = 8,
    parameter int H       = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] base_x,
    input  logic [COORD_W-1:0] base_y,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               done
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;

    logic               active;
    logic [XW-1:0]      cx;
    logic [YW-1:0]      cy;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic               last_x;
    logic               last_y;
    logic               fire;

    // Output decode: coordinates are zero whenever the stream is idle.
    always_comb begin
        last_x = (cx == XW'(W - 1));
        last_y = (cy == YW'(H - 1));
        fire   = active && ready;
        done   = fire && last_x && last_y;
        valid  = active;
        x      = active ? bx + COORD_W'(cx) : '0;
        y      = active ? by + COORD_W'(cy) : '0;
    end

    // Walk the rectangle; advance only on an accepted pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            cx     <= '0;
            cy     <= '0;
            bx     <= '0;
            by     <= '0;
        end else if (start) begin
            active <= 1'b1;
            cx     <= '0;
            cy     <= '0;
            bx     <= base_x;
            by     <= base_y;
        end else if (fire) begin
            if (last_x) begin
                cx <= '0;
                if (last_y) begin
                    active <= 1'b0;
                end else begin
                    cy <= cy + YW'(1);
                end
            end else begin
                cx <= cx + XW'(1);
            end
        end
    end

endmodule

// File: rtl/brick_field.sv
// ROWS x COLS breakout brick array with collision queries.
// Draws the whole field on init and erases each brick that is hit.
module brick_field
    import brick_pkg::*;
#(
    parameter int                  ROWS         = 2,
    parameter int                  COLS         = 5,
    parameter int                  COORD_W      = 8,
    parameter int                  ORIGIN_X     = 15,
    parameter int                  ORIGIN_Y     = 30,
    parameter int                  PITCH_X      = 30,
    parameter int                  PITCH_Y      = 4,
    parameter int                  BRICK_W      = 8,
    parameter int                  BRICK_H      = 2,
    parameter logic [COLOUR_W-1:0] BRICK_COLOUR = GREEN
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             init,
    input  logic                             chk_valid,
    output logic                             chk_ready,
    input  logic [COORD_W-1:0]               ball_x,
    input  logic [COORD_W-1:0]               ball_y,
    output logic                             hit_valid,
    output logic                             hit,
    output logic [$clog2(ROWS*COLS)-1:0]     hit_idx,
    output logic                             pix_valid,
    input  logic                             pix_ready,
    output logic [COORD_W-1:0]               pix_x,
    output logic [COORD_W-1:0]               pix_y,
    output logic [COLOUR_W-1:0]              pix_colour,
    output logic [$clog2(ROWS*COLS+1)-1:0]   bricks_left,
    output logic                             cleared
);

    localparam int N   = ROWS * COLS;
    localparam int IW  = $clog2(N);
    localparam int LW  = $clog2(N + 1);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW  = COORD_W + 1;

    localparam int EXT_X = field_extent(ORIGIN_X, PITCH_X, COLS, BRICK_W);
    localparam int EXT_Y = field_extent(ORIGIN_Y, PITCH_Y, ROWS, BRICK_H);

    if (N < 2 || BRICK_W < 1 || BRICK_H < 1 ||
        ORIGIN_X < 0 || ORIGIN_Y < 0 ||
        EXT_X > (1 << COORD_W) ||
        EXT_Y > (1 << COORD_W)) begin : g_bad_params
        $error("brick_field: field does not fit the coordinate range");
    end

    state_t             state;
    state_t             state_nx;
    logic [N-1:0]       alive;
    logic [IW-1:0]      cur_idx;
    logic [RW-1:0]      cur_row;
    logic [CLW-1:0]     cur_col;
    logic [RW-1:0]      nxt_row;
    logic [CLW-1:0]     nxt_col;
    logic [COORD_W-1:0] ball_xq;
    logic [COORD_W-1:0] ball_yq;
    logic [CW-1:0]      lo_x;
    logic [CW-1:0]      lo_y;
    logic               in_rect;
    logic               is_hit;
    logic               last_idx;
    logic               adv;

    logic               r_start;
    logic [RW-1:0]      r_row;
    logic [CLW-1:0]     r_col;
    logic [COORD_W-1:0] r_bx;
    logic [COORD_W-1:0] r_by;
    logic               r_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_done;

    // Bounds of the brick under the scan pointer, widened to avoid wrap.
    always_comb begin
        lo_x = CW'(ORIGIN_X) + CW'(cur_col) * CW'(PITCH_X);
        lo_y = CW'(ORIGIN_Y) + CW'(cur_row) * CW'(PITCH_Y);
        in_rect = ({1'b0, ball_xq} >= lo_x) &&
                  ({1'b0, ball_xq} <= lo_x + CW'(BRICK_W - 1)) &&
                  ({1'b0, ball_yq} >= lo_y) &&
                  ({1'b0, ball_yq} <= lo_y + CW'(BRICK_H - 1));
        is_hit   = (state == CHECK) && alive[cur_idx] && in_rect;
        last_idx = (cur_idx == IW'(N - 1));
        if (cur_col == CLW'(COLS - 1)) begin
            nxt_col = '0;
            nxt_row = cur_row + RW'(1);
        end else begin
            nxt_col = cur_col + CLW'(1);
            nxt_row = cur_row;
        end
    end

    // Next state, raster launch and scan-pointer advance.
    always_comb begin
        state_nx = state;
        r_start  = 1'b0;
        r_row    = '0;
        r_col    = '0;
        adv      = 1'b0;
        if (init) begin
            state_nx = DRAW_ALL;
            r_start  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (chk_valid) state_nx = CHECK;
                end
                CHECK: begin
                    if (is_hit) begin
                        state_nx = ERASE;
                        r_start  = 1'b1;
                        r_row    = cur_row;
                        r_col    = cur_col;
                    end else if (last_idx) begin
                        state_nx = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
                DRAW_ALL: begin
                    if (r_done) begin
                        if (last_idx) begin
                            state_nx = IDLE;
                        end else begin
                            adv     = 1'b1;
                            r_start = 1'b1;
                            r_row   = nxt_row;
                            r_col   = nxt_col;
                        end
                    end
                end
                ERASE: begin
                    if (r_done) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        r_bx = COORD_W'(ORIGIN_X) + COORD_W'(r_col) * COORD_W'(PITCH_X);
        r_by = COORD_W'(ORIGIN_Y) + COORD_W'(r_row) * COORD_W'(PITCH_Y);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Scan pointer shared by collision search and field drawing.
    always_ff @(posedge clock) begin
        if (reset || init) begin
            cur_idx <= '0;
            cur_row <= '0;
            cur_col <= '0;
        end else if (adv) begin
            cur_idx <= cur_idx + IW'(1);
            cur_row <= nxt_row;
            cur_col <= nxt_col;
        end else if (state == IDLE && chk_valid) begin
            cur_idx <= '0;
            cur_row <= '0;
            cur_col <= '0;
        end
    end

    // Brick bookkeeping and the registered query response.
    always_ff @(posedge clock) begin
        if (reset) begin
            alive       <= '0;
            bricks_left <= '0;
            cleared     <= 1'b0;
            hit_valid   <= 1'b0;
            hit         <= 1'b0;
            hit_idx     <= '0;
            ball_xq     <= '0;
            ball_yq     <= '0;
        end else begin
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            if (init) begin
                alive       <= '1;
                bricks_left <= LW'(N);
                cleared     <= 1'b0;
            end else if (state == IDLE && chk_valid) begin
                ball_xq <= ball_x;
                ball_yq <= ball_y;
            end else if (is_hit) begin
                alive[cur_idx] <= 1'b0;
                bricks_left    <= bricks_left - LW'(1);
                if (bricks_left == LW'(1)) cleared <= 1'b1;
                hit_valid      <= 1'b1;
                hit            <= 1'b1;
                hit_idx        <= cur_idx;
            end else if (state == CHECK && last_idx) begin
                hit_valid <= 1'b1;
                hit_idx   <= '0;
            end
        end
    end

    rect_raster #(
        .COORD_W (COORD_W),
        .W       (BRICK_W),
        .H       (BRICK_H)
    ) u_raster (
        .clock  (clock),
        .reset  (reset),
        .start  (r_start),
        .base_x (r_bx),
        .base_y (r_by),
        .ready  (pix_ready),
        .valid  (r_valid),
        .x      (r_x),
        .y      (r_y),
        .done   (r_done)
    );

    // Output mapping; erase pixels are black.
    always_comb begin
        chk_ready  = (state == IDLE);
        pix_valid  = r_valid;
        pix_x      = r_x;
        pix_y      = r_y;
        pix_colour = BLACK;
        if (r_valid && state == DRAW_ALL) pix_colour = BRICK_COLOUR;
    end

endmodule

// File: tb/tb_brick_field.sv
// Randomised bench for brick_field against a geometric model.
// Pixel stream, query responses and counters are all compared.
module tb_brick_field;

    localparam int ROWS = 2;
    localparam int COLS = 5;
    localparam int N    = ROWS * COLS;
    localparam int W    = 8;
    localparam int H    = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       init;
    logic       chk_valid;
    logic       chk_ready;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic       hit_valid;
    logic       hit;
    logic [3:0] hit_idx;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_colour;
    logic [3:0] bricks_left;
    logic       cleared;

    brick_field dut (
        .clock       (clock),
        .reset       (reset),
        .init        (init),
        .chk_valid   (chk_valid),
        .chk_ready   (chk_ready),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .hit_valid   (hit_valid),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .bricks_left (bricks_left),
        .cleared     (cleared)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    bit          m_alive [N];
    int          m_left;
    bit          m_clr;
    logic [18:0] expq[$];

    function automatic int bx(input int i);
        return 15 + (i % COLS) * 30;
    endfunction

    function automatic int by(input int i);
        return 30 + (i / COLS) * 4;
    endfunction

    function automatic int model_find(input int x, input int y);
        for (int i = 0; i < N; i++)
            if (m_alive[i] && x >= bx(i) && x < bx(i) + W &&
                y >= by(i) && y < by(i) + H)
                return i;
        return -1;
    endfunction

    task automatic push_brick(input int i, input int col);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                expq.push_back({8'(bx(i) + xx), 8'(by(i) + yy), 3'(col)});
    endtask

    bit         q_busy = 0;
    bit         abort  = 0;
    int         xfer_cnt = 0;
    int         first_x, first_y, last_x, last_y, last_c;
    int         rmode = 0;
    logic       pv_q = 0, pr_q = 0;
    logic [7:0] px_q, py_q;
    logic [2:0] pc_q;

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ~pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clock) begin
        logic [18:0] e;
        if (pv_q && !pr_q && !abort) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_x", pix_x, px_q);
            chk("stall_y", pix_y, py_q);
            chk("stall_colour", pix_colour, pc_q);
        end
        abort = 0;
        if (pix_valid && pix_ready) begin
            chk("pixel_expected", int'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pix_x", pix_x, e[18:11]);
                chk("pix_y", pix_y, e[10:3]);
                chk("pix_colour", pix_colour, e[2:0]);
            end
            if (xfer_cnt == 0) begin
                first_x = pix_x;
                first_y = pix_y;
            end
            last_x = pix_x;
            last_y = pix_y;
            last_c = pix_colour;
            xfer_cnt++;
        end
        if (!q_busy) chk("stray_hit_valid", hit_valid, 0);
        if (chk_ready) chk("idle_pix_valid", pix_valid, 0);
        pv_q = pix_valid;
        pr_q = pix_ready;
        px_q = pix_x;
        py_q = pix_y;
        pc_q = pix_colour;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        foreach (m_alive[i]) m_alive[i] = 0;
        m_left = 0;
        m_clr  = 0;
        expq.delete();
        abort  = 1;
        q_busy = 0;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        foreach (m_alive[i]) m_alive[i] = 1;
        m_left = N;
        m_clr  = 0;
        expq.delete();
        for (int i = 0; i < N; i++) push_brick(i, 2);
        abort    = 1;
        q_busy   = 0;
        xfer_cnt = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(chk_ready && expq.size() == 0 && !pix_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(n < 3000), 1);
        chk("bricks_left", bricks_left, m_left);
        chk("cleared", cleared, m_clr);
    endtask

    task automatic query(input int x, input int y, input bit hold,
                         output bit oh, output int oi, output int olat);
        int h;
        int elat;
        chk("chk_ready_before_query", chk_ready, 1);
        ball_x    = 8'(x);
        ball_y    = 8'(y);
        chk_valid = 1'b1;
        tick();
        chk_valid = 1'b0;
        ball_x    = 8'($urandom);
        ball_y    = 8'($urandom);
        h    = model_find(x, y);
        elat = (h >= 0) ? h + 1 : N;
        if (h >= 0) begin
            m_alive[h] = 0;
            m_left--;
            if (m_left == 0) m_clr = 1;
            push_brick(h, 0);
        end
        xfer_cnt = 0;
        q_busy   = 1;
        olat     = -1;
        oh       = 0;
        oi       = -1;
        for (int k = 1; k <= N + 2; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (hit_valid) begin
                if (olat < 0) begin
                    olat = k;
                    oh   = hit;
                    oi   = hit_idx;
                end else begin
                    chk("hit_valid_width", k, olat);
                end
            end
        end
        q_busy = 0;
        tick();
        chk("hit_latency", olat, elat);
        chk("hit", oh, int'(h >= 0));
        if (h >= 0) chk("hit_idx", oi, h);
        if (!hold) wait_idle();
    endtask

    task automatic query_abort(input int x, input int y, input int delay);
        chk("chk_ready_before_abort", chk_ready, 1);
        ball_x    = 8'(x);
        ball_y    = 8'(y);
        chk_valid = 1'b1;
        tick();
        chk_valid = 1'b0;
        repeat (delay) tick();
        do_init();
        wait_idle();
    endtask

    bit oh;
    int oi, ol;

    initial begin
        reset     = 1'b1;
        init      = 1'b0;
        chk_valid = 1'b0;
        ball_x    = '0;
        ball_y    = '0;
        repeat (3) tick();
        do_reset();
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_pix_colour", pix_colour, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_bricks_left", bricks_left, 0);
        chk("rst_cleared", cleared, 0);
        chk("rst_chk_ready", chk_ready, 1);

        do_init();
        wait_idle();
        chk("draw_count", xfer_cnt, 160);
        chk("draw_first_x", first_x, 15);
        chk("draw_first_y", first_y, 30);
        chk("draw_last_x", last_x, 142);
        chk("draw_last_y", last_y, 35);
        chk("draw_colour", last_c, 2);
        chk("draw_left", bricks_left, 10);
        chk("draw_ready", chk_ready, 1);

        query(16, 30, 0, oh, oi, ol);
        chk("q0_hit", oh, 1);
        chk("q0_idx", oi, 0);
        chk("q0_lat", ol, 1);
        chk("q0_erase_cnt", xfer_cnt, 16);
        chk("q0_erase_last_x", last_x, 22);
        chk("q0_erase_last_y", last_y, 31);
        chk("q0_left", bricks_left, 9);

        query(16, 30, 0, oh, oi, ol);
        chk("q1_hit", oh, 0);
        chk("q1_lat", ol, 10);
        chk("q1_pixels", xfer_cnt, 0);

        do_init();
        wait_idle();
        query(14, 30, 0, oh, oi, ol);
        chk("edge_left_hit", oh, 0);
        query(23, 31, 0, oh, oi, ol);
        chk("edge_right_hit", oh, 0);
        query(22, 31, 0, oh, oi, ol);
        chk("edge_inside_hit", oh, 1);
        chk("edge_inside_idx", oi, 0);

        rmode = 1;
        query(45, 34, 0, oh, oi, ol);
        chk("stall_hit_idx", oi, 6);
        chk("stall_xfers", xfer_cnt, 16);
        rmode = 0;

        do_init();
        wait_idle();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                query(18 + 30 * c, 30 + 4 * r, 0, oh, oi, ol);
                chk("sweep_idx", oi, r * COLS + c);
            end
        chk("sweep_cleared", cleared, 1);
        chk("sweep_left", bricks_left, 0);
        query(18, 30, 0, oh, oi, ol);
        chk("after_clear_hit", oh, 0);
        do_init();
        wait_idle();
        chk("reinit_cleared", cleared, 0);
        chk("reinit_left", bricks_left, 10);

        query_abort(140, 34, 3);
        query_abort(0, 0, 5);
        query(16, 30, 1, oh, oi, ol);
        do_init();
        wait_idle();
        chk("abort_erase_left", bricks_left, 10);

        do_init();
        repeat (20) tick();
        do_reset();
        @(negedge clock);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_left", bricks_left, 0);
        chk("mid_rst_ready", chk_ready, 1);
        tick();
        query(16, 30, 0, oh, oi, ol);
        chk("post_rst_hit", oh, 0);
        do_init();
        wait_idle();
        chk("redraw_first_x", first_x, 15);
        chk("redraw_first_y", first_y, 30);

        for (int it = 0; it < 60; it++) begin
            rmode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                do_init();
                wait_idle();
            end else begin
                query($urandom_range(5, 160), $urandom_range(25, 40),
                      0, oh, oi, ol);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
